// File: rtl/bru_pkg.sv
// bru_pkg: shared types and constants for the branch resolve unit.
package bru_pkg;
    localparam int ADDR_W      = 64;
    localparam int INSTR_BYTES = 4;

    typedef enum logic {RUN, FLUSH} bru_state_t;

    // Fields are sized for the widest supported address; narrower units zero-extend.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              hit;
        logic [ADDR_W-1:0] target;
    } pred_entry_t;
endpackage

// File: rtl/branch_resolve_unit_pred_queue.sv
// pred_queue: in-order FIFO of in-flight predictions with push/pop/clear.
module pred_queue
    import bru_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t push_data,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                do_push, do_pop;
    pred_entry_t         mem_q [DEPTH];

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign head  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    always_comb begin
        do_push  = push && !full && !clear;
        do_pop   = pop && !empty && !clear;
        wr_ptr_d = clear ? '0 : do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = clear ? '0 : do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data;
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pairs IF predictions with EX outcomes, drives BTB updates and mispredict redirects.
// Define BRU_PERF_CNT_EN to add saturating branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DEPTH_LOG2 = 2
`ifdef BRU_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH  = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_valid,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic                  pred_hit,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  pred_ready,
    input  logic                  res_valid,
    input  logic                  res_is_branch,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_target,
    output logic [ADDR_WIDTH-1:0] pc_ex,
    output logic                  branch_taken_ex,
    output logic [ADDR_WIDTH-1:0] target_addr_ex,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  mispredict_count
`endif
);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);

    bru_state_t            state_q, state_d;
    pred_entry_t           head, push_entry;
    logic                  full, empty, push, resolve, taken, mispredict;
    logic [ADDR_WIDTH-1:0] head_pc, head_target, actual_next, pred_next;
    logic                  branch_taken_ex_q, branch_taken_ex_d;
    logic [ADDR_WIDTH-1:0] pc_ex_q, pc_ex_d, target_addr_ex_q, target_addr_ex_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

    assign pred_ready = !full && state_q == RUN;
    assign push       = pred_valid && pred_ready;
    assign push_entry = '{pc: ADDR_W'(pred_pc), hit: pred_hit, target: ADDR_W'(pred_target)};

    pred_queue #(.DEPTH_LOG2(DEPTH_LOG2)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (resolve),
        .clear     (mispredict),
        .push_data (push_entry),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        head_pc           = head.pc[ADDR_WIDTH-1:0];
        head_target       = head.target[ADDR_WIDTH-1:0];
        taken             = res_is_branch && res_taken;
        resolve           = res_valid && !empty && state_q == RUN;
        actual_next       = taken ? res_target : head_pc + STEP;
        pred_next         = head.hit ? head_target : head_pc + STEP;
        mispredict        = resolve && actual_next != pred_next;
        state_d           = mispredict ? FLUSH : RUN;
        branch_taken_ex_d = resolve && taken;
        pc_ex_d           = branch_taken_ex_d ? head_pc : pc_ex_q;
        target_addr_ex_d  = branch_taken_ex_d ? res_target : target_addr_ex_q;
        redirect_pc_d     = mispredict ? actual_next : redirect_pc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= RUN;
            branch_taken_ex_q <= 1'b0;
            pc_ex_q           <= '0;
            target_addr_ex_q  <= '0;
            redirect_pc_q     <= '0;
        end else begin
            state_q           <= state_d;
            branch_taken_ex_q <= branch_taken_ex_d;
            pc_ex_q           <= pc_ex_d;
            target_addr_ex_q  <= target_addr_ex_d;
            redirect_pc_q     <= redirect_pc_d;
        end
    end

    assign branch_taken_ex = branch_taken_ex_q;
    assign pc_ex           = pc_ex_q;
    assign target_addr_ex  = target_addr_ex_q;
    assign redirect_pc     = redirect_pc_q;
    assign redirect_valid  = state_q == FLUSH;
    assign flush           = state_q == FLUSH;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;

    always_comb begin
        branch_count_d     = (resolve && res_is_branch && !(&branch_count_q)) ?
                             branch_count_q + CNT_WIDTH'(1) : branch_count_q;
        mispredict_count_d = (mispredict && !(&mispredict_count_q)) ?
                             mispredict_count_q + CNT_WIDTH'(1) : mispredict_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`endif

    // A resolve with nothing in flight means the pipeline lost track of an instruction.
    always @(posedge clk) begin
        if (!reset && state_q == RUN && res_valid)
            assert (!empty) else $warning("res_valid with empty prediction queue ignored");
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and random stimulus against a queue-based reference model.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid, pred_hit, pred_ready;
    logic [63:0] pred_pc, pred_target;
    logic        res_valid, res_is_branch, res_taken;
    logic [63:0] res_target;
    logic [63:0] pc_ex, target_addr_ex, redirect_pc;
    logic        branch_taken_ex, redirect_valid, flush;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_count, mispredict_count;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk             (clk),
        .reset           (reset),
        .pred_valid      (pred_valid),
        .pred_pc         (pred_pc),
        .pred_hit        (pred_hit),
        .pred_target     (pred_target),
        .pred_ready      (pred_ready),
        .res_valid       (res_valid),
        .res_is_branch   (res_is_branch),
        .res_taken       (res_taken),
        .res_target      (res_target),
        .pc_ex           (pc_ex),
        .branch_taken_ex (branch_taken_ex),
        .target_addr_ex  (target_addr_ex),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush)
`ifdef BRU_PERF_CNT_EN
        ,
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        logic        hit;
        logic [63:0] tgt;
    } ent_t;

    ent_t        mq[$];
    logic        m_flush, m_bt;
    logic [63:0] m_pcex, m_tex, m_rpc;
    int unsigned m_bc, m_mc;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush = 0; m_bt = 0; m_pcex = 0; m_tex = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
    endtask

    task automatic check_all();
        chk("pred_ready", {63'b0, pred_ready}, {63'b0, (mq.size() < 4) && !m_flush});
        chk("branch_taken_ex", {63'b0, branch_taken_ex}, {63'b0, m_bt});
        chk("pc_ex", pc_ex, m_pcex);
        chk("target_addr_ex", target_addr_ex, m_tex);
        chk("redirect_valid", {63'b0, redirect_valid}, {63'b0, m_flush});
        chk("flush", {63'b0, flush}, {63'b0, m_flush});
        if (m_flush) chk("redirect_pc", redirect_pc, m_rpc);
`ifdef BRU_PERF_CNT_EN
        chk("branch_count", {32'b0, branch_count}, {32'b0, m_bc});
        chk("mispredict_count", {32'b0, mispredict_count}, {32'b0, m_mc});
`endif
    endtask

    // Reference behaviour for one clock edge given the inputs currently driven.
    task automatic model_edge();
        ent_t        h;
        logic [63:0] act, prd;
        logic        was_full, mis;
        was_full = mq.size() >= 4;
        mis = 0;
        m_bt = 0;
        if (m_flush) begin
            m_flush = 0;
        end else begin
            if (res_valid && mq.size() > 0) begin
                h = mq.pop_front();
                act = (res_is_branch && res_taken) ? res_target : h.pc + 64'd4;
                prd = h.hit ? h.tgt : h.pc + 64'd4;
                if (res_is_branch && m_bc != 32'hFFFF_FFFF) m_bc++;
                if (res_is_branch && res_taken) begin
                    m_bt = 1; m_pcex = h.pc; m_tex = res_target;
                end
                if (act != prd) begin
                    mis = 1; m_rpc = act; mq.delete(); m_flush = 1;
                    if (m_mc != 32'hFFFF_FFFF) m_mc++;
                end
            end
            if (pred_valid && !was_full && !mis) mq.push_back('{pred_pc, pred_hit, pred_target});
        end
    endtask

    task automatic step(input logic pv, input logic [63:0] ppc, input logic ph, input logic [63:0] ptg,
                        input logic rv, input logic rb, input logic rt, input logic [63:0] rtg);
        pred_valid = pv; pred_pc = ppc; pred_hit = ph; pred_target = ptg;
        res_valid = rv; res_is_branch = rb; res_taken = rt; res_target = rtg;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic push(input logic [63:0] pc, input logic hit, input logic [63:0] tgt);
        step(1, pc, hit, tgt, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic rb, input logic rt, input logic [63:0] rtg);
        step(0, 0, 0, 0, 1, rb, rt, rtg);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1;
        pred_valid = 0; pred_pc = 0; pred_hit = 0; pred_target = 0;
        res_valid = 0; res_is_branch = 0; res_taken = 0; res_target = 0;
        model_reset();
        #1;
        check_all();
        chk("reset_redirect_pc", redirect_pc, 64'h0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    initial begin
        ent_t        h;
        logic        pv, ph, rv, rb, rt;
        logic [63:0] ppc, ptg, rtg;
        apply_reset();
        // correct taken prediction updates BTB only
        push(64'h100, 1, 64'h200);
        resolve(1, 1, 64'h200);
        chk("tp1_bt", {63'b0, branch_taken_ex}, 64'h1);
        chk("tp1_pc_ex", pc_ex, 64'h100);
        chk("tp1_redirect", {63'b0, redirect_valid}, 64'h0);
        idle();
        // miss then taken: BTB update together with redirect
        push(64'h104, 0, 64'h0);
        resolve(1, 1, 64'h400);
        chk("tp2_redirect_pc", redirect_pc, 64'h400);
        chk("tp2_flush", {63'b0, flush}, 64'h1);
        idle();
        // predicted taken, actually not taken
        push(64'h108, 1, 64'h300);
        resolve(1, 0, 64'h0);
        chk("tp3_redirect_pc", redirect_pc, 64'h10C);
        idle();
        // fill, overflow push, pop, wrap
        for (int i = 0; i < 4; i++) push(64'h10 + 64'(i * 4), 1, 64'h1000 + 64'(i));
        chk("full_ready", {63'b0, pred_ready}, 64'h0);
        push(64'h20, 1, 64'h2000);
        resolve(1, 1, 64'h1000);
        chk("pop_ready", {63'b0, pred_ready}, 64'h1);
        for (int i = 1; i < 4; i++) step(1, 64'h30 + 64'(i * 4), 1, 64'h3000 + 64'(i), 1, 1, 1, 64'h1000 + 64'(i));
        for (int i = 1; i < 4; i++) resolve(1, 1, 64'h3000 + 64'(i));
        chk("wrap_order_pc", pc_ex, 64'h3C);
        // mispredict with 3 younger entries and a simultaneous push
        for (int i = 0; i < 4; i++) push(64'h500 + 64'(i * 4), 0, 64'h0);
        step(1, 64'h600, 0, 0, 1, 1, 1, 64'h800);
        step(1, 64'h604, 0, 0, 1, 0, 0, 0);
        resolve(0, 0, 0);
        chk("empty_resolve_bt", {63'b0, branch_taken_ex}, 64'h0);
        // reset asserted during FLUSH
        push(64'h700, 1, 64'h900);
        resolve(0, 0, 0);
        apply_reset();
        // five branches, two mispredicts
        for (int i = 0; i < 5; i++) begin
            push(64'hA00 + 64'(i * 4), 1, 64'hB00);
            resolve(1, 1, (i < 2) ? 64'hC00 : 64'hB00);
            if (i < 2) idle();
        end
`ifdef BRU_PERF_CNT_EN
        chk("cnt_branches", {32'b0, branch_count}, 64'd5);
        chk("cnt_mispredicts", {32'b0, mispredict_count}, 64'd2);
`endif
        // random traffic, mostly correct predictions so the queue gets deep
        for (int n = 0; n < 600; n++) begin
            pv = $urandom_range(0, 2) != 0;
            ph = $urandom_range(0, 1) == 1;
            ppc = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {32'h0, $urandom} & ~64'h3;
            ptg = {$urandom, $urandom} & ~64'h3;
            rv = $urandom_range(0, 1) == 1;
            rb = $urandom_range(0, 1) == 1;
            rt = $urandom_range(0, 1) == 1;
            rtg = {32'h0, $urandom} & ~64'h3;
            if (mq.size() > 0 && $urandom_range(0, 4) != 0) begin
                h = mq[0];
                rt = h.hit;
                if (h.hit) begin rb = 1; rtg = h.tgt; end
            end
            step(pv, ppc, ph, ptg, rv, rb, rt, rtg);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
